// File: rtl/s64x7_bus_memory_pkg.sv
// Purpose: shared FSM state encodings and bus width constants for S64X7 bus responders.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package s64x7_bus_memory_pkg;

    localparam int ADR_W = 61;  // word address, byte address bits [63:3]
    localparam int DAT_W = 64;
    localparam int SEL_W = 8;   // one enable per byte lane
    localparam int CNT_W = 4;   // wait-state counter, 0..15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/s64x7_ram64.sv
// Purpose: 2^ADDR_BITS x 64 synchronous word array, byte-lane writes, registered read port.
// Latency: 1 cycle, read data registered on the edge where rd_en_i is high.
// Backpressure: none; rdat_o holds its value until the next read.
//
// Ports:
//   clk_i, reset_i  clock and synchronous reset (reset clears rdat_o only, contents kept)
//   wr_en_i, be_i   write strobe and byte-lane enables
//   rd_en_i         read strobe; loads rdat_o from mem[idx_i]
//   idx_i, wdat_i   word index and write data
//   rdat_o          registered read data
module s64x7_ram64
    import s64x7_bus_memory_pkg::*;
#(
    parameter int    ADDR_BITS = 10,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 wr_en_i,
    input  logic                 rd_en_i,
    input  logic [SEL_W-1:0]     be_i,
    input  logic [ADDR_BITS-1:0] idx_i,
    input  logic [DAT_W-1:0]     wdat_i,
    output logic [DAT_W-1:0]     rdat_o
);

    logic [DAT_W-1:0] mem [2**ADDR_BITS];

    // Array kept out of reset so it maps onto block RAM with byte enables.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int n = 0; n < SEL_W; n++) begin
                if (be_i[n]) begin
                    mem[idx_i][8*n +: 8] <= wdat_i[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdat_o <= '0;
        end else if (rd_en_i) begin
            rdat_o <= mem[idx_i];
        end
    end

    initial begin
        for (int i = 0; i < 2**ADDR_BITS; i++) begin
            mem[i] = '0;
        end
    end

endmodule

// File: rtl/s64x7_bus_memory.sv
// Purpose: S64X7 bus responder fronting a 64-bit word memory with window decode and wait states.
// Latency: request sampled at edge 0, ack_o/err_o high for one cycle after edge WAIT_STATES+1.
// Backpressure: initiator holds cyc/stb until ack/err; dropping cyc/stb during wait aborts silently.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   adr_i[63:3]             word address; upper bits decoded against BASE
//   cyc_i, stb_i            bus cycle and transfer strobe
//   sel_i, we_i, dat_i      byte lanes, write enable, write data
//   vpa_i                   instruction fetch qualifier; a fetch-qualified write is refused
//   ack_o, err_o, dat_o     one-cycle acknowledge / error, read data (held until next read)
module s64x7_bus_memory
    import s64x7_bus_memory_pkg::*;
#(
    parameter logic [63:0] BASE        = 64'hE000_0000_0000_0000,
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 0,
    parameter bit          READ_ONLY   = 1'b0,
    parameter string       INIT_FILE   = ""
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [63:3]      adr_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             we_i,
    input  logic             vpa_i,
    input  logic [DAT_W-1:0] dat_i,
    output logic             ack_o,
    output logic             err_o,
    output logic [DAT_W-1:0] dat_o
);

    localparam int TAG_LSB = ADDR_BITS + 3;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             resp_err;   // kind of response chosen on the edge entering RESP

    logic req;
    logic hit;
    logic refuse;
    logic go_resp;

    assign req    = cyc_i & stb_i;
    assign hit    = req && (adr_i[63:TAG_LSB] == BASE[63:TAG_LSB]);
    assign refuse = we_i && (READ_ONLY || vpa_i);

    // The memory access itself happens on the edge that enters RESP, with
    // the bus fields present at that edge; ack/err follow one edge later.
    // WAIT only watches cyc/stb, the window was qualified in IDLE.
    assign go_resp = !reset_i &&
                     (((state == ST_IDLE) && hit && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && req && (cnt == CNT_W'(1))));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (go_resp) begin
                resp_err <= refuse;
            end
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        cnt   <= CNT_W'(WAIT_STATES);
                        state <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    // Issued even if the initiator has already let go.
                    ack_o <= !resp_err;
                    err_o <= resp_err;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    s64x7_ram64 #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_en_i (go_resp && we_i && !refuse),
        .rd_en_i (go_resp && !we_i),
        .be_i    (sel_i),
        .idx_i   (adr_i[ADDR_BITS+2:3]),
        .wdat_i  (dat_i),
        .rdat_o  (dat_o)
    );

endmodule
